// File: rtl/key_flag_gen.sv
// Debouncer for active-low piano buttons: one flag pulse plus note code per accepted press.
// Optional auto-repeat while a key stays held is enabled by defining KEY_AUTOREPEAT_EN.
module key_flag_gen #(
    parameter int          KEY_W        = 7,
    parameter logic [23:0] CNT_20MS_MAX = 24'd2_499_999,
    parameter logic [27:0] CNT_DLY_MAX  = 28'd62_499_999,
    parameter logic [27:0] CNT_RPT_MAX  = 28'd31_249_999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic             flag,
    output logic [3:0]       key_code,
    output logic             key_held
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    // Lowest index whose bit is 0; unused upper bits are padded high so they never win.
    function automatic logic [3:0] lowest_low(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            idx = v[i] ? idx : 4'(i);
        end
        return idx;
    endfunction

    logic [KEY_W-1:0] sync1_r;
    logic [KEY_W-1:0] ks_r;
    logic [15:0]      ks_pad_s;
    logic             any_pressed_s;
    logic [3:0]       lowest_pressed_s;
    logic             sel_up_s;

    state_t           state_r;
    logic [3:0]       sel_r;
    logic [23:0]      cnt_r;

`ifdef KEY_AUTOREPEAT_EN
    logic [27:0]      rpt_cnt_r;
    logic             rpt_phase_r;
    logic [27:0]      rpt_limit_s;

    assign rpt_limit_s = rpt_phase_r ? CNT_RPT_MAX : CNT_DLY_MAX;
`else
    logic             unused_rpt_cfg_s;

    assign unused_rpt_cfg_s = ^{CNT_DLY_MAX, CNT_RPT_MAX};
`endif

    assign ks_pad_s         = {{(16-KEY_W){1'b1}}, ks_r};
    assign any_pressed_s    = ~(&ks_pad_s);
    assign lowest_pressed_s = lowest_low(ks_pad_s);
    assign sel_up_s         = ks_pad_s[sel_r];

    // Two-flop synchronizer; idles at all-ones (no key pressed).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {KEY_W{1'b1}};
            ks_r    <= {KEY_W{1'b1}};
        end else begin
            sync1_r <= key_in;
            ks_r    <= sync1_r;
        end
    end

    // Debounce FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sel_r       <= 4'd0;
            cnt_r       <= 24'd0;
            flag        <= 1'b0;
            key_code    <= 4'd0;
            key_held    <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_r   <= 28'd0;
            rpt_phase_r <= 1'b0;
`endif
        end else begin
            flag <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= 24'd0;
                    if (any_pressed_s) begin
                        sel_r   <= lowest_pressed_s;
                        state_r <= PRESS_FILT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESS_FILT: begin
                    if (sel_up_s) begin
                        cnt_r   <= 24'd0;
                        state_r <= IDLE;
                    end else if (cnt_r == CNT_20MS_MAX) begin
                        cnt_r       <= 24'd0;
                        state_r     <= HELD;
                        flag        <= 1'b1;
                        key_code    <= sel_r + 4'd1;
                        key_held    <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt_r   <= 28'd0;
                        rpt_phase_r <= 1'b0;
`endif
                    end else begin
                        cnt_r <= cnt_r + 24'd1;
                    end
                end
                HELD: begin
                    cnt_r <= 24'd0;
                    if (sel_up_s) begin
                        state_r     <= REL_FILT;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt_r   <= 28'd0;
                        rpt_phase_r <= 1'b0;
`endif
                    end else begin
                        state_r <= HELD;
`ifdef KEY_AUTOREPEAT_EN
                        // First repeat after the initial delay, then at the repeat period.
                        if (rpt_cnt_r == rpt_limit_s) begin
                            flag        <= 1'b1;
                            rpt_cnt_r   <= 28'd0;
                            rpt_phase_r <= 1'b1;
                        end else begin
                            rpt_cnt_r <= rpt_cnt_r + 28'd1;
                        end
`endif
                    end
                end
                REL_FILT: begin
                    if (!sel_up_s) begin
                        // Release bounce: resume holding without a new flag.
                        cnt_r       <= 24'd0;
                        state_r     <= HELD;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt_r   <= 28'd0;
                        rpt_phase_r <= 1'b0;
`endif
                    end else if (cnt_r == CNT_20MS_MAX) begin
                        cnt_r    <= 24'd0;
                        state_r  <= IDLE;
                        key_code <= 4'd0;
                        key_held <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + 24'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= 24'd0;
                    key_code <= 4'd0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_flag_gen.sv
// Directed bench for key_flag_gen with short debounce/repeat counts.
module tb_key_flag_gen;

    logic       clk;
    logic       rst_n;
    logic [6:0] key_in;
    logic       flag;
    logic [3:0] key_code;
    logic       key_held;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef KEY_AUTOREPEAT_EN
    localparam int EXP_RPT_50  = 1;
    localparam int EXP_RPT_100 = 5;
`else
    localparam int EXP_RPT_50  = 0;
    localparam int EXP_RPT_100 = 0;
`endif

    key_flag_gen #(
        .KEY_W        (7),
        .CNT_20MS_MAX (24'd9),
        .CNT_DLY_MAX  (28'd29),
        .CNT_RPT_MAX  (28'd14)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .flag     (flag),
        .key_code (key_code),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs are driven at negedge and outputs sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_flag(input int budget, output int cycles);
        cycles = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (flag === 1'b1) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic wait_release(input int budget, output int cycles);
        cycles = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (key_held === 1'b0) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad_cycles;
        rst_n  = 1'b0;
        key_in = 7'h7F;
        repeat (3) tick();
        n_cmp++; if (flag !== 1'b0)     begin n_bad++; $display("FAIL reset_flag got=%b exp=0", flag); end
        n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL reset_code got=%0d exp=0", key_code); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset_held got=%b exp=0", key_held); end
        rst_n = 1'b1;
        bad_cycles = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (flag !== 1'b0 || key_code !== 4'd0 || key_held !== 1'b0) bad_cycles++;
        end
        n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL idle_quiet got=%0d active cycles exp=0", bad_cycles); end
    endtask

    task automatic test_single_press();
        int c;
        int extra;
        int held_low;
        key_in = 7'h7B;
        wait_flag(40, c);
        n_cmp++; if (c !== 13)           begin n_bad++; $display("FAIL press_latency got=%0d exp=13", c); end
        n_cmp++; if (key_code !== 4'd3)  begin n_bad++; $display("FAIL press_code got=%0d exp=3", key_code); end
        n_cmp++; if (key_held !== 1'b1)  begin n_bad++; $display("FAIL press_held got=%b exp=1", key_held); end
        extra = 0;
        held_low = 0;
        for (int k = 0; k < 37; k++) begin
            tick();
            if (flag === 1'b1) extra++;
            if (key_held !== 1'b1) held_low++;
        end
        n_cmp++; if (extra !== EXP_RPT_50) begin n_bad++; $display("FAIL press_extra_flags got=%0d exp=%0d", extra, EXP_RPT_50); end
        n_cmp++; if (held_low !== 0)       begin n_bad++; $display("FAIL press_held_drop got=%0d exp=0", held_low); end
        key_in = 7'h7F;
        wait_release(40, c);
        n_cmp++; if (c !== 13)           begin n_bad++; $display("FAIL release_latency got=%0d exp=13", c); end
        n_cmp++; if (key_code !== 4'd0)  begin n_bad++; $display("FAIL release_code got=%0d exp=0", key_code); end
    endtask

    task automatic test_press_bounce();
        int flags;
        int held;
        flags = 0;
        held  = 0;
        for (int r = 0; r < 6; r++) begin
            key_in = 7'h7E;
            for (int k = 0; k < 5; k++) begin
                tick();
                if (flag === 1'b1) flags++;
                if (key_held !== 1'b0) held++;
            end
            key_in = 7'h7F;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (flag === 1'b1) flags++;
                if (key_held !== 1'b0) held++;
            end
        end
        for (int k = 0; k < 15; k++) begin
            tick();
            if (flag === 1'b1) flags++;
            if (key_held !== 1'b0) held++;
        end
        n_cmp++; if (flags !== 0) begin n_bad++; $display("FAIL bounce_flags got=%0d exp=0", flags); end
        n_cmp++; if (held !== 0)  begin n_bad++; $display("FAIL bounce_held got=%0d exp=0", held); end
    endtask

    task automatic test_release_glitch();
        int c;
        int flags;
        int held_low;
        key_in = 7'h6F;
        wait_flag(40, c);
        n_cmp++; if (c !== 13)          begin n_bad++; $display("FAIL glitch_latency got=%0d exp=13", c); end
        n_cmp++; if (key_code !== 4'd5) begin n_bad++; $display("FAIL glitch_code got=%0d exp=5", key_code); end
        repeat (5) tick();
        flags = 0;
        held_low = 0;
        key_in = 7'h7F;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (flag === 1'b1) flags++;
            if (key_held !== 1'b1) held_low++;
        end
        key_in = 7'h6F;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (flag === 1'b1) flags++;
            if (key_held !== 1'b1) held_low++;
        end
        n_cmp++; if (flags !== 0)       begin n_bad++; $display("FAIL glitch_flags got=%0d exp=0", flags); end
        n_cmp++; if (held_low !== 0)    begin n_bad++; $display("FAIL glitch_held_drop got=%0d exp=0", held_low); end
        n_cmp++; if (key_code !== 4'd5) begin n_bad++; $display("FAIL glitch_code_after got=%0d exp=5", key_code); end
        key_in = 7'h7F;
        wait_release(40, c);
        n_cmp++; if (c !== 13)          begin n_bad++; $display("FAIL glitch_release got=%0d exp=13", c); end
    endtask

    task automatic test_simultaneous();
        int c;
        key_in = 7'h5D;
        wait_flag(40, c);
        n_cmp++; if (c !== 13)          begin n_bad++; $display("FAIL simul_latency got=%0d exp=13", c); end
        n_cmp++; if (key_code !== 4'd2) begin n_bad++; $display("FAIL simul_code got=%0d exp=2", key_code); end
        repeat (5) tick();
        key_in = 7'h5F;
        wait_release(40, c);
        n_cmp++; if (c !== 13)          begin n_bad++; $display("FAIL simul_release got=%0d exp=13", c); end
        n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL simul_release_code got=%0d exp=0", key_code); end
        wait_flag(40, c);
        n_cmp++; if (c !== 11)          begin n_bad++; $display("FAIL second_key_latency got=%0d exp=11", c); end
        n_cmp++; if (key_code !== 4'd6) begin n_bad++; $display("FAIL second_key_code got=%0d exp=6", key_code); end
        n_cmp++; if (key_held !== 1'b1) begin n_bad++; $display("FAIL second_key_held got=%b exp=1", key_held); end
        key_in = 7'h7F;
        wait_release(40, c);
        n_cmp++; if (c !== 13)          begin n_bad++; $display("FAIL second_key_release got=%0d exp=13", c); end
    endtask

    task automatic test_reset_midop();
        int c;
        int rpts;
        int off[5];
        key_in = 7'h3F;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (flag !== 1'b0 || key_code !== 4'd0 || key_held !== 1'b0) begin
            n_bad++; $display("FAIL midreset_outputs got=%b/%0d/%b exp=0/0/0", flag, key_code, key_held);
        end
        tick();
        rst_n = 1'b1;
        wait_flag(40, c);
        n_cmp++; if (c !== 13)          begin n_bad++; $display("FAIL midreset_latency got=%0d exp=13", c); end
        n_cmp++; if (key_code !== 4'd7) begin n_bad++; $display("FAIL midreset_code got=%0d exp=7", key_code); end
        rpts = 0;
        for (int i = 0; i < 5; i++) off[i] = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (flag === 1'b1) begin
                if (rpts < 5) off[rpts] = k;
                rpts++;
            end
        end
        n_cmp++; if (rpts !== EXP_RPT_100) begin n_bad++; $display("FAIL repeat_count got=%0d exp=%0d", rpts, EXP_RPT_100); end
`ifdef KEY_AUTOREPEAT_EN
        n_cmp++; if (off[0] !== 30) begin n_bad++; $display("FAIL repeat_first got=%0d exp=30", off[0]); end
        n_cmp++; if (off[1] !== 45) begin n_bad++; $display("FAIL repeat_second got=%0d exp=45", off[1]); end
        n_cmp++; if (off[2] !== 60) begin n_bad++; $display("FAIL repeat_third got=%0d exp=60", off[2]); end
`endif
        n_cmp++; if (key_code !== 4'd7) begin n_bad++; $display("FAIL hold_code got=%0d exp=7", key_code); end
        // Asynchronous reset while HELD must clear outputs before any clock edge.
        rst_n = 1'b0;
        #1;
        n_cmp++; if (key_held !== 1'b0 || key_code !== 4'd0) begin
            n_bad++; $display("FAIL held_reset got=%b/%0d exp=0/0", key_held, key_code);
        end
        key_in = 7'h7F;
        tick();
        rst_n = 1'b1;
        c = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (flag !== 1'b0 || key_held !== 1'b0) c++;
        end
        n_cmp++; if (c !== 0) begin n_bad++; $display("FAIL post_reset_quiet got=%0d exp=0", c); end
    endtask

    initial begin
        rst_n  = 1'b0;
        key_in = 7'h7F;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_press_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_flag_gen.md
Name: key_flag_gen

Overview:
- Upstream stage of the piano buzzer: debounces the raw, active-low piano push-buttons.
- For each debounced press it emits a single-cycle `flag` pulse and a note code (1=Do … 7=Si).
- The buzzer consumes `flag` to start playback and may consume `key_code`.
- Single 125 MHz clock domain; the buttons are asynchronous inputs.

Parameters:
- KEY_W, 7, number of button inputs (max 15).
- CNT_20MS_MAX, 24'd2_499_999, debounce terminal count (20 ms at 125 MHz).
- CNT_DLY_MAX, 28'd62_499_999, auto-repeat initial delay (500 ms). Used only with KEY_AUTOREPEAT_EN.
- CNT_RPT_MAX, 28'd31_249_999, auto-repeat period (250 ms). Used only with KEY_AUTOREPEAT_EN.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- key_in, input, KEY_W, raw buttons; 0 = pressed; asynchronous.
- flag, output, 1, one-cycle pulse per accepted press.
- key_code, output, 4, index+1 of the accepted key; 0 = none.
- key_held, output, 1, high while the accepted key is debounced-down.

Behaviour:
- Reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`, with all state cleared immediately on assertion. Reset values: `flag`=0, `key_code`=0, `key_held`=0, FSM=IDLE, counters=0, synchronizer flops=all 1s.
- Synchronizer: 2-flop synchronizer per bit of `key_in`. The FSM uses only the synchronized value, `ks`.
- Counter: one debounce counter, 24 bits. It is cleared on every state change and increments by 1 per cycle in PRESS_FILT and REL_FILT.
- IDLE:
  - If any `ks` bit is 0: latch `sel` = lowest pressed index (a fixed priority encoder) and go to PRESS_FILT.
  - Otherwise stay in IDLE.
- PRESS_FILT:
  - If `ks[sel]` returns to 1 before the count completes: go to IDLE with no output.
  - If the counter reaches CNT_20MS_MAX with `ks[sel]` still 0: go to HELD.
  - Other keys are ignored.
- HELD:
  - On entry: `flag`=1 for exactly the first HELD cycle; `key_code` = `sel`+1, registered in the same cycle as `flag` and stable until released; `key_held`=1.
  - When `ks[sel]` = 1: go to REL_FILT.
- REL_FILT:
  - If `ks[sel]` returns to 0 before the count completes: go back to HELD with no new `flag` (bounce on release).
  - If the counter reaches CNT_20MS_MAX with `ks[sel]` = 1: go to IDLE, and `key_code` and `key_held` go to 0 on that cycle.
- Latency: a clean press of key i appears as `flag` exactly 2 (sync) + 1 (IDLE detect) + CNT_20MS_MAX+1 (filter) cycles after the `key_in` falling edge. Total = CNT_20MS_MAX+4 clocks.
- Other keys: a second key that is still down when IDLE is re-entered is treated as a fresh press and is filtered from zero.
- Simultaneous presses: the lowest index wins.
- `flag` is never high for two consecutive cycles without the auto-repeat feature.
- Reset mid-operation: everything aborts immediately. After `rst_n` deasserts, a still-held key re-debounces and produces a new `flag`.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- When defined:
  - HELD runs a 28-bit repeat counter.
  - After CNT_DLY_MAX+1 cycles in HELD, `flag` pulses for one cycle.
  - After that, `flag` pulses every CNT_RPT_MAX+1 cycles while HELD.
  - `key_code` is unchanged by repeat pulses.
  - The repeat counter clears on entry to REL_FILT. Re-entering HELD from REL_FILT restarts the initial delay.
- When undefined: no repeat counter is synthesised, and exactly one `flag` is produced per press.

Test Plan (KEY_W=7, CNT_20MS_MAX=9, CNT_DLY_MAX=29, CNT_RPT_MAX=14):
- Reset then idle, all `key_in`=7'h7F for 100 cycles -> `flag`=0, `key_code`=0, `key_held`=0 throughout.
- `key_in[2]` driven low and held for 50 cycles -> exactly one `flag` pulse, 13 cycles after the edge; `key_code`=3; `key_held`=1 until release filtering completes, then `key_code`=0.
- `key_in[0]` low for 5 cycles, high for 3, repeated 6 times (press bounce) -> no `flag`; FSM returns to IDLE.
- `key_in[4]` held until `key_held`=1, then a 4-cycle high glitch, then held low again -> no second `flag`; `key_code` stays 5.
- `key_in[1]` and `key_in[5]` go low on the same cycle -> one `flag` with `key_code`=2. Release `key_in[1]` only -> after release filtering, a second `flag` with `key_code`=6.
- `rst_n` pulsed low during PRESS_FILT of `key_in[6]`, key still held -> outputs 0 immediately; `flag` with `key_code`=7 occurs 13 cycles after `rst_n` rises. With KEY_AUTOREPEAT_EN, holding for 100 cycles -> repeat flags 30, 45 and 60 cycles after the first.
